// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the control sequencer:
// opcode mnemonics, FSM states and instruction field positions.
package ctrl_sequencer_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    ADI = 4'd1,
    AND = 4'd2,
    OR0 = 4'd3,
    XOR = 4'd4,
    BNE = 4'd5,
    SLL = 4'd6,
    SRL = 4'd7,
    ZER = 4'd8,
    PAR = 4'd9,
    MOL = 4'd10,
    MOU = 4'd11,
    LDR = 4'd12,
    STR = 4'd13,
    NOP = 4'd14,
    HLT = 4'd15
  } op_mne;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    WB
  } seq_state_t;

  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 5;
  localparam int RS_MSB  = 4;
  localparam int RS_LSB  = 2;
  localparam int IMM_MSB = 1;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/ctrl_sequencer_instr_decode.sv
// Combinational instruction decoder: IR to ALU controls,
// register indices and instruction class bits.
module instr_decode
  import ctrl_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [8:0]   ir,
  output op_mne        alu_op,
  output logic         imm_sel,
  output logic [W-1:0] imm,
  output logic [2:0]   reg_addr_b,
  output logic [2:0]   reg_wr_addr,
  output logic         is_alu,
  output logic         is_branch,
  output logic         is_load,
  output logic         is_store,
  output logic         is_halt
);

  op_mne      op;
  logic [2:0] rs;

  assign op  = op_mne'(ir[OPC_MSB:OPC_LSB]);
  assign rs  = ir[RS_MSB:RS_LSB];
  assign imm = {{(W-2){1'b0}}, ir[IMM_MSB:IMM_LSB]};

  always_comb begin
    alu_op      = ZER;
    imm_sel     = 1'b0;
    reg_addr_b  = rs;
    reg_wr_addr = 3'd0;
    is_alu      = 1'b0;
    is_branch   = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_halt     = 1'b0;
    unique case (op)
      ADI, SLL, SRL: begin
        alu_op  = op;
        imm_sel = 1'b1;
        is_alu  = 1'b1;
      end
      BNE: begin
        alu_op    = op;
        is_alu    = 1'b1;
        is_branch = 1'b1;
      end
      // MOL copies R0 into R[Rs]
      MOL: begin
        alu_op      = op;
        is_alu      = 1'b1;
        reg_addr_b  = 3'd0;
        reg_wr_addr = rs;
      end
      LDR: is_load  = 1'b1;
      STR: is_store = 1'b1;
      HLT: is_halt  = 1'b1;
      NOP: ;
      default: begin
        alu_op = op;
        is_alu = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: FSM, PC, IR and flag registers
// driving the ALU, register file and data memory.
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Start,
  output logic [W-1:0]   InstAddr,
  input  logic [8:0]     Inst,
  output logic [Ops-1:0] AluOp,
  output logic [2:0]     RegAddrB,
  output logic           ImmSel,
  output logic [W-1:0]   Imm,
  input  logic           AluZero,
  input  logic           AluPar,
  input  logic [W-1:0]   BrTarget,
  output logic           RegWrEn,
  output logic [2:0]     RegWrAddr,
  output logic           WbSel,
  output logic           MemReq,
  output logic           MemWe,
  input  logic           MemAck,
  output logic           ZeroFlag,
  output logic           ParFlag,
  output logic           Done
);

  seq_state_t     state, nxt;
  logic [W-1:0]   pc;
  logic [8:0]     ir;

  op_mne          d_op;
  logic           d_imm_sel;
  logic           d_alu, d_branch, d_load, d_store, d_halt;
  logic           d_wr;
  logic           alu_phase;

  instr_decode #(.W(W)) u_dec (
    .ir          (ir),
    .alu_op      (d_op),
    .imm_sel     (d_imm_sel),
    .imm         (Imm),
    .reg_addr_b  (RegAddrB),
    .reg_wr_addr (RegWrAddr),
    .is_alu      (d_alu),
    .is_branch   (d_branch),
    .is_load     (d_load),
    .is_store    (d_store),
    .is_halt     (d_halt)
  );

  assign d_wr = d_alu & ~d_branch;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (Start) nxt = FETCH;
      FETCH: nxt = EXEC;
      EXEC: begin
        unique case (1'b1)
          d_halt:            nxt = IDLE;
          d_load | d_store:  nxt = MEM;
          d_wr:              nxt = WB;
          default:           nxt = FETCH;
        endcase
      end
      MEM:   if (MemAck) nxt = d_load ? WB : FETCH;
      WB:    nxt = FETCH;
      default: nxt = IDLE;
    endcase
  end

  // PC advances once per instruction, on leaving EXEC
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc       <= '0;
      ir       <= '0;
      ZeroFlag <= 1'b0;
      ParFlag  <= 1'b0;
      Done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            pc   <= '0;
            Done <= 1'b0;
          end
        end
        FETCH: ir <= Inst;
        EXEC: begin
          if (d_alu) begin
            ZeroFlag <= AluZero;
            ParFlag  <= AluPar;
          end
          if (d_halt)                    Done <= 1'b1;
          else if (d_branch && !AluZero) pc   <= BrTarget;
          else                           pc   <= pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_phase = (state == EXEC) || (state == WB);

  assign InstAddr = pc;
  assign AluOp    = alu_phase ? Ops'(d_op) : Ops'(ZER);
  assign ImmSel   = alu_phase & d_imm_sel;
  assign RegWrEn  = (state == WB);
  assign WbSel    = (state == WB) & d_load;
  assign MemReq   = (state == MEM);
  assign MemWe    = (state == MEM) & d_store;

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle control sequencer that drives the combinational ALU, register file and data memory of the CSE141L core. It fetches 9-bit instructions, decodes them into an ALU opcode and operand selects, latches the ALU status flags, and issues register writebacks. It also performs branches and handshaked loads/stores. It is the issuing end of the ALU opcode/flag interface.

## Interface
- W, 8, datapath/PC width
- Ops, 4, ALU opcode width
- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  begin execution from IDLE at PC 0
- InstAddr  out  W  program counter
- Inst  in  9  instruction at InstAddr, valid same cycle (combinational ROM)
- AluOp  out  Ops  ALU opcode, op_mne encoding
- RegAddrB  out  3  register file read port B index (port A hardwired to R0)
- ImmSel  out  1  1 = ALU InputB takes Imm instead of R[RegAddrB]
- Imm  out  W  zero-extended 2-bit immediate
- AluZero  in  1  ALU zero flag
- AluPar  in  1  ALU parity flag
- BrTarget  in  W  contents of R7 (branch target)
- RegWrEn  out  1  register write strobe
- RegWrAddr  out  3  register write index
- WbSel  out  1  0 = ALU Out, 1 = memory read data
- MemReq  out  1  data memory request, address = R[RegAddrB]
- MemWe  out  1  1 = store R0, 0 = load
- MemAck  in  1  memory completes request this cycle
- ZeroFlag, ParFlag  out  1 each  flags latched at end of EXEC
- Done  out  1  high in IDLE after HLT

## Operation
- Instruction fields: [8:5] opcode, [4:2] Rs, [1:0] imm2.
- Opcodes: ADD=0, ADI=1, AND=2, OR0=3, XOR=4, BNE=5, SLL=6, SRL=7, ZER=8, PAR=9, MOL=10, MOU=11, LDR=12, STR=13, NOP=14, HLT=15.
- Opcodes 0–11 drive AluOp = opcode. LDR, STR, NOP and HLT drive AluOp = ZER.
- ImmSel=1 for ADI, SLL and SRL. Otherwise operand B = R[Rs].
- Destination is R0, except MOL, which writes R[Rs] with R0; RegAddrB=0 for MOL.
- BNE, STR, NOP and HLT do not write a register.
- BNE: ALU computes R0−R[Rs]. If AluZero=0 during EXEC, PC ← BrTarget. Otherwise PC ← PC+1.
- States: IDLE, FETCH, EXEC, MEM, WB.
  - IDLE: Start → FETCH with PC←0 and Done←0.
  - FETCH: IR←Inst, then → EXEC.
  - EXEC: ZeroFlag←AluZero and ParFlag←AluPar for all ALU ops (unchanged for LDR/STR/NOP/HLT).
    - HLT → IDLE with Done←1.
    - LDR/STR → MEM.
    - BNE/NOP → FETCH.
    - Otherwise → WB.
  - MEM: MemReq=1 held until MemAck. On ack: LDR → WB (WbSel=1); STR → FETCH.
  - WB: RegWrEn=1 for one cycle, then → FETCH.
- PC advances by 1 when leaving EXEC (non-branch) or when leaving MEM/WB for instructions not yet advanced; each instruction advances PC exactly once. PC wraps 255→0.
- Start is ignored outside IDLE.

## Timing
- Reset (async): state=IDLE, PC=0, IR=0, ZeroFlag=ParFlag=Done=0. All strobes 0, AluOp=ZER.
- Reset asserted mid-MEM drops MemReq immediately; the transaction is abandoned.
- Outputs are Moore (functions of state and IR only); no combinational input→output path.
- Cycle counts: ALU op = 3 (FETCH, EXEC, WB); BNE/NOP = 2; STR = 2+N; LDR = 3+N (N ≥ 1 MEM cycles, N=1 when MemAck is high in the first MEM cycle); HLT = 2.
- MemAck outside MEM is ignored. No timeout.
- RegWrEn, MemReq and MemWe never assert in the same cycle.

## Structure
- Definitions package holds:
  - op_mne enum, extended with LDR, STR, NOP, HLT
  - seq_state_t enum
  - field-position constants for opcode, Rs and imm2
- One combinational sub-module, instr_decode: IR → AluOp, ImmSel, Imm, RegAddrB, RegWrAddr, class bits (alu, branch, load, store, halt).
- ctrl_sequencer holds the FSM, PC, IR and flag registers.

## Test plan
- Reset then Start; ROM[0]=ADI Rs=0 imm=3 → AluOp=1, Imm=3, ImmSel=1; RegWrEn at cycle 3 with RegWrAddr=0; InstAddr=1 in next FETCH.
- BNE with ALU model returning Out≠0 (AluZero=0), BrTarget=8'h40 → next FETCH InstAddr=8'h40. Repeat with AluZero=1 → InstAddr=PC+1. No RegWrEn in either case.
- LDR with MemAck delayed 3 cycles → MemReq high exactly 3 cycles, MemWe=0, then one WB cycle with WbSel=1.
- STR with MemAck immediate → MemReq=1 and MemWe=1 for 1 cycle, then FETCH; no RegWrEn.
- PC=255 executing NOP → next InstAddr=0. HLT → Done=1 and state IDLE; Start → PC=0 and Done=0.
- Reset_n asserted during MEM wait → MemReq=0 asynchronously, PC=0, Done=0. Start pulses outside IDLE have no effect.
